// File: rtl/ram_seq_ctrl.sv
// ram_seq_ctrl: drives address, write data and write enable of the 32x4
// synchronous RAM stage. It has three modes: manual pass-through of the
// switches, an automatic fill of every word with one constant, and a read
// scan that walks the addresses at a rate set by TICK_DIV.
module ram_seq_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 4,
  parameter int TICK_DIV = 4
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic [1:0]        Cmd,
  input  logic              ManWrite,
  input  logic [ADDR_W-1:0] ManAddr,
  input  logic [DATA_W-1:0] ManData,
  input  logic [DATA_W-1:0] FillData,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] DataIn,
  output logic              Write,
  output logic              Busy,
  output logic              Done,
  output logic              Wrap
);

  localparam int TICK_W = $clog2(TICK_DIV + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [1:0] CMD_FILL = 2'b01;
  localparam logic [1:0] CMD_SCAN = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    SCAN,
    DONE
  } state_t;

  state_t            state;
  logic              start_prev;
  logic              start_edge;
  logic [ADDR_W-1:0] fill_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic              scan_init;

  // A start request is the cycle where Start is high but was low one cycle earlier.
  assign start_edge = Start & ~start_prev;

  // Sequencer: every output is registered here; state changes become visible on the RAM ports one cycle later.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state      <= IDLE;
      start_prev <= 1'b0;
      fill_cnt   <= '0;
      tick_cnt   <= '0;
      scan_init  <= 1'b0;
      Address    <= '0;
      DataIn     <= '0;
      Write      <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Wrap       <= 1'b0;
    end else begin
      start_prev <= Start;
      Done       <= 1'b0;
      Wrap       <= 1'b0;

      case (state)
        IDLE: begin
          Address <= ManAddr;
          DataIn  <= ManData;
          Write   <= ManWrite;
          Busy    <= 1'b0;
          if (start_edge) begin
            if (Cmd == CMD_FILL) begin
              state    <= FILL;
              fill_cnt <= '0;
            end else if (Cmd == CMD_SCAN) begin
              state     <= SCAN;
              scan_init <= 1'b1;
              tick_cnt  <= '0;
            end
          end
        end

        FILL: begin
          Address  <= fill_cnt;
          DataIn   <= FillData;
          Write    <= 1'b1;
          Busy     <= 1'b1;
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_cnt == ADDR_LAST) begin
            state <= DONE;
          end
        end

        DONE: begin
          Write <= 1'b0;
          Busy  <= 1'b0;
          Done  <= 1'b1;
          state <= IDLE;
        end

        SCAN: begin
          Write <= 1'b0;
          if (start_edge) begin
            state     <= IDLE;
            Busy      <= 1'b0;
            scan_init <= 1'b0;
          end else begin
            Busy <= 1'b1;
            if (scan_init) begin
              scan_init <= 1'b0;
              Address   <= '0;
              tick_cnt  <= '0;
            end else if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              Address  <= Address + 1'b1;
              if (Address == ADDR_LAST) begin
                Wrap <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// tb_ram_seq_ctrl: directed bench for ram_seq_ctrl with a small model of the
// downstream 32x4 RAM (write on Write, registered read of Address).
module tb_ram_seq_ctrl;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 4;
  localparam int TICK_DIV = 4;

  logic              Clock = 1'b0;
  logic              Resetn;
  logic              Start;
  logic [1:0]        Cmd;
  logic              ManWrite;
  logic [ADDR_W-1:0] ManAddr;
  logic [DATA_W-1:0] ManData;
  logic [DATA_W-1:0] FillData;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] DataIn;
  logic              Write;
  logic              Busy;
  logic              Done;
  logic              Wrap;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] mem [32];
  logic [DATA_W-1:0] ram_q;

  ram_seq_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .Start   (Start),
    .Cmd     (Cmd),
    .ManWrite(ManWrite),
    .ManAddr (ManAddr),
    .ManData (ManData),
    .FillData(FillData),
    .Address (Address),
    .DataIn  (DataIn),
    .Write   (Write),
    .Busy    (Busy),
    .Done    (Done),
    .Wrap    (Wrap)
  );

  // Free-running system clock.
  always #5 Clock = ~Clock;

  // Downstream RAM model fed only by the sequencer outputs.
  always @(posedge Clock) begin
    if (Write) mem[Address] <= DataIn;
    ram_q <= mem[Address];
  end

  // Hard time limit so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Resetn = 1'b0; Start = 1'b1; ManWrite = 1'b1; ManAddr = 5'h05;
    ManData = 4'h9; Cmd = 2'b00; FillData = 4'h0;
    repeat (3) step();
    checks++;
    if (Address !== 5'h00) begin errors++; $display("[TB] FAIL reset_address: got %0h expected 0", Address); end
    checks++;
    if (DataIn !== 4'h0) begin errors++; $display("[TB] FAIL reset_datain: got %0h expected 0", DataIn); end
    checks++;
    if ({Write, Busy, Done, Wrap} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {Write, Busy, Done, Wrap});
    end
    Resetn = 1'b1; ManWrite = 1'b0;
    step();
    checks++;
    if (Address !== 5'h05 || Busy !== 1'b0) begin
      errors++; $display("[TB] FAIL post_reset_idle: got addr=%0h busy=%b expected addr=5 busy=0", Address, Busy);
    end
    Cmd = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (Busy !== 1'b0 || Write !== 1'b0) begin
        errors++; $display("[TB] FAIL held_start_no_edge: got busy=%b write=%b expected 0 0", Busy, Write);
      end
    end
    Start = 1'b0; Cmd = 2'b00;
    step();
  endtask

  task automatic test_manual();
    ManAddr = 5'h13; ManData = 4'hA; ManWrite = 1'b1;
    step();
    checks++;
    if (Address !== 5'h13 || DataIn !== 4'hA || Write !== 1'b1) begin
      errors++; $display("[TB] FAIL manual_write: got %0h/%0h/%b expected 13/a/1", Address, DataIn, Write);
    end
    ManWrite = 1'b0; ManAddr = 5'h02;
    step();
    ManAddr = 5'h13;
    step();
    step();
    checks++;
    if (ram_q !== 4'hA) begin
      errors++; $display("[TB] FAIL manual_readback: got %0h expected a", ram_q);
    end
    ManAddr = 5'h07; ManData = 4'h3;
    step();
    checks++;
    if (Address !== 5'h07 || DataIn !== 4'h3 || Write !== 1'b0) begin
      errors++; $display("[TB] FAIL manual_pattern2: got %0h/%0h/%b expected 7/3/0", Address, DataIn, Write);
    end
  endtask

  task automatic test_fill();
    logic [ADDR_W-1:0] exp_addr;
    Cmd = 2'b01; FillData = 4'h7; ManWrite = 1'b0; Start = 1'b1;
    step();
    Start = 1'b0;
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL fill_edge_cycle_busy: got %b expected 0", Busy); end
    step();
    checks++;
    if (Address !== 5'h00 || Write !== 1'b1 || Busy !== 1'b1 || DataIn !== 4'h7) begin
      errors++; $display("[TB] FAIL fill_first: got a=%0h w=%b b=%b d=%0h expected 0 1 1 7", Address, Write, Busy, DataIn);
    end
    for (int k = 1; k < 32; k++) begin
      step();
      exp_addr = 5'(k);
      checks++;
      if (Address !== exp_addr || Write !== 1'b1 || Done !== 1'b0) begin
        errors++; $display("[TB] FAIL fill_word: got a=%0h w=%b done=%b expected a=%0h w=1 done=0", Address, Write, Done, exp_addr);
      end
    end
    step();
    checks++;
    if (Done !== 1'b1 || Busy !== 1'b0 || Write !== 1'b0 || Address !== 5'h1F) begin
      errors++; $display("[TB] FAIL fill_done: got done=%b busy=%b w=%b a=%0h expected 1 0 0 1f", Done, Busy, Write, Address);
    end
    Cmd = 2'b00;
    step();
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("[TB] FAIL fill_done_single: got done=%b busy=%b expected 0 0", Done, Busy);
    end
    for (int a = 0; a < 32; a++) begin
      ManAddr = 5'(a);
      step();
      step();
      checks++;
      if (ram_q !== 4'h7) begin
        errors++; $display("[TB] FAIL fill_readback: addr %0d got %0h expected 7", a, ram_q);
      end
    end
  endtask

  task automatic test_scan();
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_wrap;
    Cmd = 2'b10; ManAddr = 5'h1C; Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    checks++;
    if (Address !== 5'h00 || Busy !== 1'b1 || Write !== 1'b0 || Wrap !== 1'b0) begin
      errors++; $display("[TB] FAIL scan_entry: got a=%0h b=%b w=%b wrap=%b expected 0 1 0 0", Address, Busy, Write, Wrap);
    end
    Cmd = 2'b01;
    for (int s = 2; s <= 136; s++) begin
      step();
      exp_addr = 5'(((s - 1) / TICK_DIV) % 32);
      exp_wrap = (s == 129);
      checks++;
      if (Address !== exp_addr || Wrap !== exp_wrap || Busy !== 1'b1 || Done !== 1'b0) begin
        errors++; $display("[TB] FAIL scan_step %0d: got a=%0h wrap=%b b=%b expected a=%0h wrap=%b b=1", s, Address, Wrap, Busy, exp_addr, exp_wrap);
      end
    end
    Start = 1'b1;
    step();
    Start = 1'b0; Cmd = 2'b00;
    checks++;
    if (Busy !== 1'b0 || Address !== 5'h01) begin
      errors++; $display("[TB] FAIL scan_exit_hold: got b=%b a=%0h expected 0 1", Busy, Address);
    end
    step();
    checks++;
    if (Address !== 5'h1C || Busy !== 1'b0) begin
      errors++; $display("[TB] FAIL scan_exit_manual: got a=%0h b=%b expected 1c 0", Address, Busy);
    end
  endtask

  task automatic test_ignored();
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    Cmd = 2'b11; ManAddr = 5'h0B; Start = 1'b1;
    step();
    Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (Busy !== 1'b0 || Address !== 5'h0B) begin
        errors++; $display("[TB] FAIL reserved_cmd: got b=%b a=%0h expected 0 b", Busy, Address);
      end
    end
    Cmd = 2'b01; FillData = 4'h5; Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    checks++;
    if (Address !== 5'h00 || Write !== 1'b1 || DataIn !== 4'h5) begin
      errors++; $display("[TB] FAIL ign_fill_first: got a=%0h w=%b d=%0h expected 0 1 5", Address, Write, DataIn);
    end
    for (int k = 1; k < 32; k++) begin
      if (k == 5) begin Start = 1'b1; Cmd = 2'b10; end
      if (k == 6) Start = 1'b0;
      if (k == 16) FillData = 4'h6;
      step();
      exp_addr = 5'(k);
      exp_data = (k < 16) ? 4'h5 : 4'h6;
      checks++;
      if (Address !== exp_addr || Write !== 1'b1 || Busy !== 1'b1 || DataIn !== exp_data) begin
        errors++; $display("[TB] FAIL ign_fill_word: got a=%0h w=%b b=%b d=%0h expected a=%0h 1 1 d=%0h", Address, Write, Busy, DataIn, exp_addr, exp_data);
      end
    end
    Start = 1'b1;
    step();
    checks++;
    if (Done !== 1'b1 || Busy !== 1'b0) begin
      errors++; $display("[TB] FAIL ign_fill_done: got done=%b b=%b expected 1 0", Done, Busy);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (Busy !== 1'b0 || Done !== 1'b0) begin
        errors++; $display("[TB] FAIL start_in_done_ignored: got b=%b done=%b expected 0 0", Busy, Done);
      end
    end
    Start = 1'b0; Cmd = 2'b00;
    step();
  endtask

  task automatic test_abort();
    int                done_seen;
    logic [DATA_W-1:0] exp_word;
    Cmd = 2'b01; FillData = 4'h3; Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    for (int k = 1; k <= 10; k++) step();
    checks++;
    if (Address !== 5'h0A || Write !== 1'b1) begin
      errors++; $display("[TB] FAIL abort_reach10: got a=%0h w=%b expected a 1", Address, Write);
    end
    Resetn = 1'b0;
    step();
    checks++;
    if ({Address, DataIn, Write, Busy, Done, Wrap} !== 13'h0) begin
      errors++; $display("[TB] FAIL abort_reset: got a=%0h d=%0h flags=%b expected all 0", Address, DataIn, {Write, Busy, Done, Wrap});
    end
    Resetn = 1'b1; Cmd = 2'b00;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (Done === 1'b1 || Busy === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++; $display("[TB] FAIL abort_no_done: got %0d busy/done cycles expected 0", done_seen);
    end
    for (int a = 0; a < 32; a++) begin
      exp_word = (a <= 10) ? 4'h3 : ((a < 16) ? 4'h5 : 4'h6);
      checks++;
      if (mem[a] !== exp_word) begin
        errors++; $display("[TB] FAIL abort_word %0d: got %0h expected %0h", a, mem[a], exp_word);
      end
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    test_reset();
    test_manual();
    test_fill();
    test_scan();
    test_ignored();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_seq_ctrl.md
# ram_seq_ctrl

Sequencer that drives the address, data and write-enable inputs of the 32x4 synchronous RAM stage. It is placed directly upstream of the RAM, between the board switches/keys and the RAM ports. It supports three modes: manual pass-through of switch values, an automatic fill of all 32 words with one constant, and an automatic read scan that steps through the addresses at a programmable rate. The RAM's registered output is displayed downstream, so during a scan the contents cycle on the HEX digits.

## Interface
- ADDR_W, 5, address width; depth = 2^ADDR_W words
- DATA_W, 4, data word width
- TICK_DIV, 4, clock cycles per scan step; legal range ≥1

- Clock  in  1  single system clock; all logic on the rising edge
- Resetn  in  1  synchronous, active-low reset
- Start  in  1  level input; its rising edge is detected internally (registered previous value)
- Cmd  in  2  00 manual, 01 fill, 10 scan, 11 reserved (treated as manual)
- ManWrite  in  1  manual write enable
- ManAddr  in  ADDR_W  manual address
- ManData  in  DATA_W  manual write data
- FillData  in  DATA_W  constant written during a fill
- Address  out  ADDR_W  RAM address, registered
- DataIn  out  DATA_W  RAM write data, registered
- Write  out  1  RAM write enable, registered
- Busy  out  1  high in FILL and SCAN
- Done  out  1  one-cycle pulse when a fill completes
- Wrap  out  1  one-cycle pulse when the scan address wraps from 31 to 0

## Operation
- States: IDLE, FILL, SCAN, DONE. Reset → IDLE.
- Reset values: Address=0, DataIn=0, Write=0, Busy=0, Done=0, Wrap=0, tick counter=0, Start history register=0.
- Start edge: startEdge = Start & ~StartPrev, where StartPrev is Start registered one cycle.
- IDLE
  - Each cycle registers Address←ManAddr, DataIn←ManData, Write←ManWrite.
  - On startEdge: Cmd=01 → FILL; Cmd=10 → SCAN; Cmd=00 or 11 → stay in IDLE, no effect.
- FILL
  - Write=1, DataIn=FillData.
  - Address runs 0,1,…,31, one word per cycle.
  - After the cycle with Address=31 → DONE.
  - startEdge and Cmd changes are ignored. FillData is sampled every cycle; a change mid-fill affects only the remaining words.
- DONE
  - Write=0, Done=1, Address holds 31; lasts one cycle, then → IDLE.
- SCAN
  - Write=0; Address starts at 0 with the tick counter cleared.
  - Tick counter counts 0…TICK_DIV-1. At TICK_DIV-1 it returns to 0 and Address increments modulo 32.
  - On the increment from 31 to 0, Wrap=1 for that one cycle.
  - On startEdge → IDLE; the last scan address is held for one cycle and then manual values take over.
  - Cmd changes while scanning are ignored.
- Address arithmetic is unsigned ADDR_W bits and wraps naturally. The tick counter is sized ceil(log2(TICK_DIV+1)) bits.
- Resetn low on any edge overrides everything and forces the reset values, including mid-FILL (the fill is abandoned, no Done pulse).

## Timing
- Start rises so that startEdge is seen at edge n:
  - FILL: Busy=1, Write=1, Address=0 after edge n+1. Address=k after edge n+1+k. Last write (Address=31) after edge n+32. Done=1, Busy=0, Write=0 after edge n+33. Back in IDLE after edge n+34.
  - SCAN: Address=0, Busy=1 after edge n+1. Address increments every TICK_DIV cycles. Wrap is asserted in the same cycle that Address shows 0 again.
- Manual latency: Man* inputs appear on the outputs one cycle later. The RAM adds its own read register, so read data is visible 2 cycles after ManAddr changes.
- Done and Wrap are never asserted together. Busy=0 in IDLE and DONE.
- A startEdge arriving in the same cycle as the FILL→DONE transition is ignored. A startEdge in DONE is also ignored.

## Test plan
- Reset: hold Resetn=0 for 3 cycles with Start=1 and ManWrite=1 → all outputs 0. After release, no state change until Start falls and rises again.
- Manual: ManAddr=5'h13, ManData=4'hA, ManWrite=1 → next cycle Address=13, DataIn=A, Write=1. Reading back through the RAM gives DataOut=A two cycles after ManAddr is applied.
- Fill: Cmd=01, FillData=4'h7, pulse Start → 32 consecutive writes at addresses 0–31, Done pulses exactly once 33 cycles after the edge, and a manual read of every address returns 7.
- Scan: TICK_DIV=4, Cmd=10, pulse Start → Address steps every 4 cycles; Wrap pulses 128 cycles after scan entry (Address returns to 0); a second Start edge returns to IDLE and Busy=0.
- Abort: Resetn=0 at fill address 10 → outputs reset next edge, Done never pulses, words 11–31 are unchanged.
- Ignored events: Cmd=11 with Start edge → stays IDLE. A Start edge during FILL and a Cmd change to 10 → fill still completes all 32 words.
